// File: rtl/rr_fifo_arbiter_n.sv
// rr_fifo_arbiter_n: N_CH per-channel FIFOs merged round-robin onto one registered valid/ready output.
// Latency: a word written at edge k can be on dout after edge k+1; one word per cycle while ready=1.
// Backpressure: ready=0 freezes dout/grant and all reads, full writes drop; RRFA_SLOT_MODE_EN selects legacy fixed-slot arbitration.

// rrfa_fifo: DEPTH-entry circular buffer with registered count, one write and one read port.
// Latency: a pushed word is visible on rd_dat/nempty the cycle after the push edge.
// Backpressure: pushes while full are dropped, even when a pop happens on the same edge.
module rrfa_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic          nempty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          push;
    logic          pop;

    // Full is judged on the registered count, so a same-edge pop never makes room.
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign nempty = (cnt_q != '0);
    assign push   = wr_vld && !full;
    assign pop    = rd_rdy && nempty;
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end
endmodule

// rr_fifo_arbiter_n: top level, one rrfa_fifo per channel feeding a single output register.
// Latency: one cycle from write edge to earliest output; full rate while ready=1.
// Backpressure: output stage holds while valid && !ready; no FIFO is popped during a hold.
module rr_fifo_arbiter_n #(
    parameter int N_CH  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         wen,
    input  logic [N_CH*DW-1:0]      din,
    output logic [N_CH-1:0]         full,
    output logic [DW-1:0]           dout,
    output logic                    valid,
    input  logic                    ready,
    output logic [$clog2(N_CH)-1:0] grant
);
    localparam int GW = $clog2(N_CH);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HOLD  = 1'b1;
    localparam logic [GW-1:0] LAST_CH = GW'(N_CH - 1);

    logic [DW-1:0]   rd_dat [N_CH];
    logic [N_CH-1:0] nempty;
    logic [N_CH-1:0] pop;

    logic            state_q, state_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic            load_opp;
    logic            sel_vld;
    logic [GW-1:0]   sel_idx;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        rrfa_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_vld (wen[i]),
            .wr_dat (din[i*DW +: DW]),
            .rd_rdy (pop[i]),
            .rd_dat (rd_dat[i]),
            .nempty (nempty[i]),
            .full   (full[i])
        );
    end

    assign load_opp = (state_q == ST_EMPTY) || ready;

`ifdef RRFA_SLOT_MODE_EN
    // Legacy slot mode: only the next channel in rotation is ever considered.
    always_comb begin
        sel_idx = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
        sel_vld = nempty[sel_idx];
    end
`else
    logic [GW-1:0] cand;

    // Walk the rotation backwards so the nearest non-empty channel after ptr wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = ptr_q;
        cand    = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = GW'((int'(ptr_q) + k) % N_CH);
            if (nempty[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        pop     = '0;
        if (load_opp) begin
            if (sel_vld) begin
                pop[sel_idx] = 1'b1;
                state_d      = ST_HOLD;
                dout_d       = rd_dat[sel_idx];
                grant_d      = sel_idx;
                ptr_d        = sel_idx;
            end else begin
                state_d = ST_EMPTY;
                dout_d  = '0;
`ifdef RRFA_SLOT_MODE_EN
                grant_d = sel_idx;
                ptr_d   = sel_idx;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            dout_q  <= '0;
            grant_q <= '0;
            ptr_q   <= LAST_CH;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign dout  = dout_q;
    assign valid = (state_q == ST_HOLD);
    assign grant = grant_q;
endmodule

// File: tb/tb_rr_fifo_arbiter_n.sv
// Bench for rr_fifo_arbiter_n (N_CH=4, DW=8, DEPTH=8): vector table plus scoreboard-checked sequences.
module tb_rr_fifo_arbiter_n;
    localparam int N_CH  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int GW    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_CH-1:0]      wen;
    logic [N_CH*DW-1:0]   din;
    logic [N_CH-1:0]      full;
    logic [DW-1:0]        dout;
    logic                 valid;
    logic                 ready;
    logic [GW-1:0]        grant;

    rr_fifo_arbiter_n #(
        .N_CH  (N_CH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (wen),
        .din   (din),
        .full  (full),
        .dout  (dout),
        .valid (valid),
        .ready (ready),
        .grant (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0]    wen;
        logic [N_CH*DW-1:0] din;
        logic               ready;
        logic               exp_valid;
        logic [DW-1:0]      exp_dout;
        logic [GW-1:0]      exp_grant;
    } vec_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic [GW-1:0] gnt;
    } sb_t;

    vec_t tbl [6];
    sb_t  sb_q [$];
    sb_t  cur_exp;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] d);
        wen = '0;
        din = '0;
        wen[ch] = 1'b1;
        din[ch*DW +: DW] = d;
    endtask

    task automatic sb_push(input logic [DW-1:0] d, input logic [GW-1:0] g);
        sb_t e;
        e.dat = d;
        e.gnt = g;
        sb_q.push_back(e);
    endtask

    // One clock; with the monitor on, new words are popped from the scoreboard and holds re-checked.
    task automatic tick();
        logic r;
        r = ready;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (prev_valid && !r) begin
                check("hold_valid", valid, 1);
                check("hold_dout", dout, cur_exp.dat);
                check("hold_grant", grant, cur_exp.gnt);
            end else if (valid) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected: got dout %0d grant %0d, expected no word", dout, grant);
                end else begin
                    cur_exp = sb_q.pop_front();
                    check("sb_dout", dout, cur_exp.dat);
                    check("sb_grant", grant, cur_exp.gnt);
                end
            end
        end
        prev_valid = valid;
    endtask

    initial begin
        tbl[0] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd10}, 1'b1, 1'b0, 8'd0,  2'd0};
        tbl[1] = '{4'b0010, {8'd0, 8'd0, 8'd20, 8'd0}, 1'b1, 1'b1, 8'd10, 2'd0};
        tbl[2] = '{4'b0100, {8'd0, 8'd30, 8'd0, 8'd0}, 1'b1, 1'b1, 8'd20, 2'd1};
        tbl[3] = '{4'b1000, {8'd40, 8'd0, 8'd0, 8'd0}, 1'b1, 1'b1, 8'd30, 2'd2};
        tbl[4] = '{4'b0000, {8'd0, 8'd0, 8'd0, 8'd0},  1'b1, 1'b1, 8'd40, 2'd3};
        tbl[5] = '{4'b0000, {8'd0, 8'd0, 8'd0, 8'd0},  1'b1, 1'b0, 8'd0,  2'd3};
        cur_exp = '{dat: 8'd0, gnt: 2'd0};

        // Reset held with random traffic.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wen   = N_CH'($urandom);
            din   = {$urandom};
            ready = 1'($urandom);
            tick();
        end
        check("rst_dout", dout, 0);
        check("rst_valid", valid, 0);
        check("rst_grant", grant, 0);
        check("rst_full", full, 0);
        wen   = '0;
        din   = '0;
        ready = 1'b1;
        rst_n = 1'b1;
        prev_valid = 1'b0;

`ifdef RRFA_SLOT_MODE_EN
        // Only ch2 holds a word: slots ch0, ch1 bubble, ch2 delivers, then ch3, ch0, ch1 bubble.
        wr(2, 8'd9);
        tick();
        check("slot0_valid", valid, 0);
        check("slot0_grant", grant, 0);
        wen = '0;
        tick();
        check("slot1_valid", valid, 0);
        check("slot1_grant", grant, 1);
        tick();
        check("slot2_valid", valid, 1);
        check("slot2_dout", dout, 9);
        check("slot2_grant", grant, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("slot_bubble%0d_valid", i), valid, 0);
            check($sformatf("slot_bubble%0d_dout", i), dout, 0);
            check($sformatf("slot_bubble%0d_grant", i), grant, (3 + i) % N_CH);
        end
`else
        // Sequential fill, one write per cycle, output one cycle behind.
        for (int i = 0; i < 6; i++) begin
            wen   = tbl[i].wen;
            din   = tbl[i].din;
            ready = tbl[i].ready;
            tick();
            check($sformatf("vec%0d_valid", i), valid, tbl[i].exp_valid);
            check($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
            check($sformatf("vec%0d_grant", i), grant, tbl[i].exp_grant);
        end

        // Skip empty channels: ch1={5,6}, ch3={7,8} interleave with no bubble.
        mon_en = 1'b1;
        ready  = 1'b1;
        sb_push(8'd5, 2'd1);
        sb_push(8'd7, 2'd3);
        sb_push(8'd6, 2'd1);
        sb_push(8'd8, 2'd3);
        wen = 4'b1010;
        din = '0;
        din[1*DW +: DW] = 8'd5;
        din[3*DW +: DW] = 8'd7;
        tick();
        check("skip_idle_valid", valid, 0);
        din[1*DW +: DW] = 8'd6;
        din[3*DW +: DW] = 8'd8;
        tick();
        check("skip_v0", valid, 1);
        wen = '0;
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("skip_v%0d", i), valid, 1);
        end
        tick();
        check("skip_end_valid", valid, 0);
        check("skip_end_dout", dout, 0);
        check("skip_sb_empty", sb_q.size(), 0);

        // Backpressure: ch0={1,2}, ch2={3}, ready low for four cycles.
        ready = 1'b0;
        sb_push(8'd1, 2'd0);
        sb_push(8'd3, 2'd2);
        sb_push(8'd2, 2'd0);
        wen = 4'b0101;
        din = '0;
        din[0*DW +: DW] = 8'd1;
        din[2*DW +: DW] = 8'd3;
        tick();
        wr(0, 8'd2);
        tick();
        check("bp_first_valid", valid, 1);
        wen = '0;
        repeat (4) tick();
        ready = 1'b1;
        repeat (3) tick();
        check("bp_end_valid", valid, 0);
        check("bp_sb_empty", sb_q.size(), 0);

        // Full/drop: ch0 word parks in the output stage so ch2 can fill all eight entries.
        ready = 1'b0;
        sb_push(8'd55, 2'd0);
        for (int i = 0; i < DEPTH; i++) sb_push(8'(100 + i), 2'd2);
        wr(0, 8'd55);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            wr(2, 8'(100 + i));
            tick();
            if (i == DEPTH - 2) check("full_before", full, 4'b0000);
        end
        check("full_set", full, 4'b0100);
        wr(2, 8'd99);
        tick();
        check("full_drop_hold", full, 4'b0100);
        ready = 1'b1;
        wr(2, 8'd98);
        tick();
        check("full_clear_on_pop", full, 4'b0000);
        wen = '0;
        repeat (9) tick();
        check("full_end_valid", valid, 0);
        check("full_sb_empty", sb_q.size(), 0);

        // Asynchronous reset mid-stream with a full channel and a held word.
        mon_en = 1'b0;
        ready  = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(1, 8'(200 + i));
            tick();
        end
        check("pre_arst_full", full, 4'b0010);
        check("pre_arst_valid", valid, 1);
        wen = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_dout", dout, 0);
        check("arst_grant", grant, 0);
        check("arst_full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        prev_valid = 1'b0;
        mon_en = 1'b1;
        ready  = 1'b1;
        sb_push(8'd66, 2'd0);
        sb_push(8'd77, 2'd1);
        wen = 4'b0011;
        din = '0;
        din[0*DW +: DW] = 8'd66;
        din[1*DW +: DW] = 8'd77;
        tick();
        wen = '0;
        repeat (3) tick();
        check("post_arst_valid", valid, 0);
        check("post_arst_sb_empty", sb_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rr_fifo_arbiter_n.md
# rr_fifo_arbiter_n

Parametrised round-robin FIFO arbiter: N_CH independent write channels, each buffered in its own DEPTH-entry FIFO, merged onto a single registered output stream with valid/ready backpressure. Empty channels are skipped, so the output is work-conserving. It sits between multiple producers and one shared consumer, and generalises the team's fixed 4×8-bit round-robin FIFO arbiter in channel count, width and depth. It adds backpressure, full flags and a grant index.

## Interface
- N_CH, 4, number of channels (≥2)
- DW, 8, data width in bits
- DEPTH, 8, entries per channel FIFO (power of two, ≥2)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wen  input  N_CH  per-channel write enable
- din  input  N_CH*DW  channel i data at din[i*DW +: DW]
- full  output  N_CH  channel i FIFO holds DEPTH entries
- dout  output  DW  registered output data
- valid  output  1  dout holds a word
- ready  input  1  consumer accepts dout this cycle
- grant  output  $clog2(N_CH)  channel that sourced the current dout

## Operation
- Per-channel storage:
  - Circular buffer with write pointer, read pointer and a count of width $clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- Write: accepted when wen[i] && !full[i].
  - A write to a full channel is dropped silently, even if that channel is popped in the same cycle.
- Output stage states:
  - EMPTY: valid=0.
  - HOLD: valid=1, waiting on ready.
- Load opportunity: the output stage is EMPTY, or valid && ready this cycle.
- Arbitration at a load opportunity:
  - Search channels ptr+1, ptr+2, … mod N_CH.
  - Pick the first with count>0 (registered count, pre-write).
  - Pop it, load dout, set valid=1, grant=idx, ptr<=idx.
- No non-empty channel at a load opportunity: valid<=0, dout<=0; grant and ptr hold.
- ready=0 while valid=1: dout, grant, valid and every FIFO read pointer hold.
- Simultaneous push and pop on one channel: count unchanged; both pointers advance.
- A write into an empty channel is not visible to arbitration until the next cycle.
- Data order within a channel is strictly FIFO.

## Timing
- Reset (asynchronous, immediate):
  - dout=0, valid=0, grant=0, full=0.
  - All counts and pointers 0; ptr=N_CH-1, so channel 0 has first priority.
  - Reset mid-operation discards all buffered data; the first edge after rst_n rises behaves as the post-reset state.
- Latency: a word written at edge k appears on dout with valid=1 after edge k+1 at the earliest.
- Throughput: one word per cycle while ready=1 and any channel is non-empty.
- full[i] updates on the same edge as the count that reaches DEPTH.
- full[i] clears on the edge of the pop that leaves DEPTH-1 entries.
- Fairness: with all channels continuously non-empty and ready=1, grant cycles 0,1,…,N_CH-1,0,…

## Configuration
- RRFA_SLOT_MODE_EN defined (legacy slot mode):
  - At each load opportunity only channel ptr+1 mod N_CH is examined.
  - ptr always advances by one.
  - If that channel is empty: valid<=0, dout<=0, grant<=ptr+1. This produces a bubble.
- RRFA_SLOT_MODE_EN undefined: work-conserving skip-empty search as described in Operation.

## Test plan
- Reset: hold rst_n=0 with random wen/din -> dout=0, valid=0, grant=0, full=0000. Assert rst_n=0 asynchronously mid-stream -> outputs clear before the next edge.
- Sequential fill, ready=1, defaults: write 10→ch0, 20→ch1, 30→ch2, 40→ch3, one per cycle -> dout 10,20,30,40 with grant 0,1,2,3, each one cycle after its write.
- Skip empty: preload ch1={5,6}, ch3={7,8}, ready=1 -> dout 5,7,6,8 with grant 1,3,1,3, no bubbles, then valid=0 and dout=0.
- Backpressure: ch0={1,2}, ch2={3}, ready=0 for 4 cycles -> dout=1, grant=0 held stable. Release ready -> 1,3,2 in order.
- Full/drop: write 8 values 100..107 to ch2 with ready=0 -> full[2]=1. A 9th write of 99 is dropped. Drain -> 100..107 only.
- Slot mode (macro defined): only ch2 holds {9} -> valid pattern 0,0,1 with dout=9, grant=2, then bubbles on ch3, ch0, ch1.
